bank_stream_reader: RTL and testbench

BANK_STREAM_READER -- requirements
Module: bank_stream_reader

---
 rtl/bank_stream_pkg.sv | 29 ++
 rtl/bank_stream_fifo.sv | 54 +++++
 rtl/bank_stream_reader.sv | 163 ++++++++++++++++
 tb/tb_bank_stream_reader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bank_stream_pkg.sv
// Shared definitions for the bank stream reader: CSR offsets, FSM states, status bits.
package bank_stream_pkg;

  localparam int CSR_W = 32;

  localparam logic [1:0] CSR_START_ADDR = 2'd0;
  localparam logic [1:0] CSR_LENGTH     = 2'd1;
  localparam logic [1:0] CSR_CTRL       = 2'd2;
  localparam logic [1:0] CSR_PERF       = 2'd3;

  localparam int CTRL_START_BIT = 0;
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_DONE_BIT  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic [CSR_W-1:0] status_word(input logic busy, input logic done);
    logic [CSR_W-1:0] w;
    w = '0;
    w[STAT_BUSY_BIT] = busy;
    w[STAT_DONE_BIT] = done;
    return w;
  endfunction

endpackage

// File: rtl/bank_stream_fifo.sv
// Synchronous power-of-two FIFO with full/empty/count; storage is not reset.
module bank_stream_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_full,
  output logic              o_empty,
  output logic [CW-1:0]     o_count
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  // A pop frees the slot in the same cycle, so push-at-full is accepted alongside it.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/bank_stream_reader.sv
// Streams LENGTH words from a 1-cycle-latency memory bank onto a valid/ready port.
// Optional busy-cycle counter at CSR 3 when BANK_STREAM_PERF_EN is defined.
module bank_stream_reader
  import bank_stream_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int BANK_AW    = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         s_address,
  input  logic               s_read,
  input  logic               s_write,
  input  logic [31:0]        s_writedata,
  output logic [31:0]        s_readdata,
  output logic [BANK_AW-1:0] bank_address,
  output logic               bank_chipselect,
  output logic               bank_write,
  input  logic [31:0]        bank_readdata,
  output logic [31:0]        out_data,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int DATA_W = 32;
  localparam int CW     = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  state_t             r_state;
  state_t             w_state_next;
  logic [BANK_AW-1:0] r_start_addr;
  logic [BANK_AW:0]   r_length;
  logic [BANK_AW-1:0] r_addr;
  logic [BANK_AW:0]   r_remain;
  logic               r_vld_p1;
  logic               r_done;
  logic               w_busy;
  logic               w_start;
  logic               w_cfg_wr;
  logic               w_issue;
  logic               w_room;
  logic               w_done_set;
  logic               w_pop;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [CW-1:0]      w_fifo_count;
  logic [CW:0]        w_occ;
  logic [31:0]        w_perf;
  logic               w_unused_csr;

  assign w_busy   = (r_state != ST_IDLE);
  assign w_cfg_wr = s_write & ~w_busy;
  assign w_start  = w_cfg_wr & (s_address == CSR_CTRL) & s_writedata[CTRL_START_BIT];
  assign w_pop    = out_valid & out_ready;
  // Words already queued plus the one in flight must fit, so a returning read always lands.
  assign w_occ    = {1'b0, w_fifo_count} + {{CW{1'b0}}, r_vld_p1};
  assign w_room   = (w_occ < DEPTH_C);
  assign w_unused_csr = &{1'b0, s_read, s_writedata[31:BANK_AW+1], w_fifo_full};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_done_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start && (r_length != '0)) w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (w_room) begin
          w_issue = 1'b1;
          if (r_remain == {{BANK_AW{1'b0}}, 1'b1}) w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave as the last word is popped so done and the final beat line up.
        if (!r_vld_p1 && (w_fifo_empty || ((w_fifo_count == CW'(1)) && w_pop))) begin
          w_state_next = ST_IDLE;
          w_done_set   = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_start_addr <= '0;
      r_length     <= '0;
      r_addr       <= '0;
      r_remain     <= '0;
      r_vld_p1     <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      // Stage p0 -> p1: issued read returns on bank_readdata next cycle
      r_vld_p1 <= w_issue;
      if (w_cfg_wr && (s_address == CSR_START_ADDR)) r_start_addr <= s_writedata[BANK_AW-1:0];
      if (w_cfg_wr && (s_address == CSR_LENGTH))     r_length     <= s_writedata[BANK_AW:0];
      if (w_start) begin
        r_addr   <= r_start_addr;
        r_remain <= r_length;
        r_done   <= (r_length == '0);
      end else begin
        if (w_issue) begin
          r_addr   <= r_addr + 1'b1;
          r_remain <= r_remain - 1'b1;
        end
        if (w_done_set) r_done <= 1'b1;
      end
    end
  end

`ifdef BANK_STREAM_PERF_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_perf <= '0;
    else if (w_start) r_perf <= '0;
    else if (w_busy)  r_perf <= r_perf + 1'b1;
  end

  assign w_perf = r_perf;
`else
  assign w_perf = '0;
`endif

  always_comb begin
    s_readdata = '0;
    case (s_address)
      CSR_START_ADDR: s_readdata = {{(32-BANK_AW){1'b0}}, r_start_addr};
      CSR_LENGTH:     s_readdata = {{(31-BANK_AW){1'b0}}, r_length};
      CSR_CTRL:       s_readdata = status_word(w_busy, r_done);
      CSR_PERF:       s_readdata = w_perf;
      default:        s_readdata = '0;
    endcase
  end

  assign bank_chipselect = w_issue;
  assign bank_address    = r_addr;
  assign bank_write      = 1'b0;
  assign out_valid       = ~w_fifo_empty;

  // Stage p1 -> FIFO: capture the returned word
  bank_stream_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (r_vld_p1),
    .i_din   (bank_readdata),
    .i_pop   (w_pop),
    .o_dout  (out_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

endmodule

// File: tb/tb_bank_stream_reader.sv
// Directed bench for bank_stream_reader with a 1-cycle-latency bank holding mem[i]=i.
module tb_bank_stream_reader;

  localparam int FIFO_DEPTH = 4;
  localparam int BANK_AW    = 10;

  logic               clk = 1'b0;
  logic               reset;
  logic [1:0]         s_address;
  logic               s_read;
  logic               s_write;
  logic [31:0]        s_writedata;
  logic [31:0]        s_readdata;
  logic [BANK_AW-1:0] bank_address;
  logic               bank_chipselect;
  logic               bank_write;
  logic [31:0]        bank_readdata;
  logic [31:0]        out_data;
  logic               out_valid;
  logic               out_ready;

  logic [31:0] mem [0:1023];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          t0;
  int          n_iss;
  logic [31:0] iss_q[$];
  logic [31:0] out_q[$];
  int          out_cyc[$];
  logic [31:0] rd;

  always #5 clk = ~clk;

  bank_stream_reader #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .BANK_AW    (BANK_AW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .s_address       (s_address),
    .s_read          (s_read),
    .s_write         (s_write),
    .s_writedata     (s_writedata),
    .s_readdata      (s_readdata),
    .bank_address    (bank_address),
    .bank_chipselect (bank_chipselect),
    .bank_write      (bank_write),
    .bank_readdata   (bank_readdata),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bank_chipselect) bank_readdata <= mem[bank_address];
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (bank_chipselect) begin
        iss_q.push_back({22'b0, bank_address});
        n_iss = n_iss + 1;
      end
      if (out_valid && out_ready) begin
        out_q.push_back(out_data);
        out_cyc.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, want);
    end
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    s_address = a;
    s_read    = 1'b1;
    #1;
    d         = s_readdata;
    s_read    = 1'b0;
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    s_write = 1'b1; s_address = a; s_writedata = d;
    @(posedge clk); #1;
    s_write = 1'b0;
  endtask

  task automatic start_xfer();
    @(posedge clk); #1;
    out_q.delete(); iss_q.delete(); out_cyc.delete(); n_iss = 0;
    s_write = 1'b1; s_address = 2'd2; s_writedata = 32'd1;
    t0 = cyc;
    @(posedge clk); #1;
    s_write = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    logic [31:0] st;
    csr_rd(2'd2, st);
    for (int i = 0; i < maxc && st[0]; i++) begin
      @(posedge clk); #1;
      csr_rd(2'd2, st);
    end
    check("idle_timeout", {31'b0, st[0]}, 32'd0);
  endtask

  task automatic check_words(input string tag, input int base, input int n);
    logic [31:0] w;
    check({tag, "_count"}, out_q.size(), n);
    check({tag, "_issues"}, iss_q.size(), n);
    for (int i = 0; i < n; i++) begin
      w = (i < out_q.size()) ? out_q[i] : 32'hDEAD_BEEF;
      check($sformatf("%s_word%0d", tag, i), w, (base + i) % 1024);
      w = (i < iss_q.size()) ? iss_q[i] : 32'hDEAD_BEEF;
      check($sformatf("%s_addr%0d", tag, i), w, (base + i) % 1024);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = i;
    reset = 1'b1; s_address = '0; s_read = 1'b0; s_write = 1'b0; s_writedata = '0;
    out_ready = 1'b1; n_iss = 0;
    repeat (3) @(posedge clk); #1;
    check("rst_cs", {31'b0, bank_chipselect}, 32'd0);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_addr", {22'b0, bank_address}, 32'd0);
    csr_rd(2'd0, rd); check("rst_start", rd, 32'd0);
    csr_rd(2'd1, rd); check("rst_len", rd, 32'd0);
    csr_rd(2'd2, rd); check("rst_status", rd, 32'd0);
    reset = 1'b0;

    // Zero-length start: done next cycle, no bank traffic
    start_xfer();
    csr_rd(2'd2, rd); check("zl_status", rd, 32'd2);
    repeat (5) @(posedge clk); #1;
    check("zl_issues", n_iss, 32'd0);
    check("zl_words", out_q.size(), 32'd0);

    // Basic run: START=5, LENGTH=4
    csr_wr(2'd0, 32'd5);
    csr_wr(2'd1, 32'd4);
    csr_rd(2'd0, rd); check("cfg_start", rd, 32'd5);
    csr_rd(2'd1, rd); check("cfg_len", rd, 32'd4);
    start_xfer();
    csr_rd(2'd2, rd); check("run_busy", rd, 32'd1);
    wait_idle(30);
    check_words("basic", 5, 4);
    check("first_latency", (out_cyc.size() > 0) ? out_cyc[0] - t0 : -1, 32'd3);
    check("back_to_back", (out_cyc.size() > 3) ? out_cyc[3] - out_cyc[0] : -1, 32'd3);
    csr_rd(2'd2, rd); check("basic_status", rd, 32'd2);
    csr_rd(2'd3, rd);
`ifdef BANK_STREAM_PERF_EN
    check("perf", rd, 32'd6);
    repeat (4) @(posedge clk); #1;
    csr_rd(2'd3, rd); check("perf_hold", rd, 32'd6);
`else
    check("perf_off", rd, 32'd0);
`endif

    // Address wrap
    csr_wr(2'd0, 32'd1022);
    csr_wr(2'd1, 32'd4);
    start_xfer();
    wait_idle(30);
    check_words("wrap", 1022, 4);

    // Back-pressure: consumer stalled for 20 cycles
    out_ready = 1'b0;
    csr_wr(2'd0, 32'd100);
    csr_wr(2'd1, 32'd16);
    start_xfer();
    repeat (20) @(posedge clk); #1;
    check("stall_issues", n_iss, FIFO_DEPTH);
    check("stall_valid", {31'b0, out_valid}, 32'd1);
    check("stall_data", out_data, 32'd100);
    repeat (3) @(posedge clk); #1;
    check("stall_hold", out_data, 32'd100);
    out_ready = 1'b1;
    wait_idle(100);
    check_words("stall", 100, 16);

    // Writes while busy are ignored
    csr_wr(2'd0, 32'd200);
    csr_wr(2'd1, 32'd8);
    start_xfer();
    csr_wr(2'd0, 32'd500);
    csr_wr(2'd1, 32'd3);
    csr_wr(2'd2, 32'd1);
    wait_idle(50);
    check_words("busywr", 200, 8);
    csr_rd(2'd0, rd); check("busywr_start", rd, 32'd200);
    csr_rd(2'd1, rd); check("busywr_len", rd, 32'd8);

    // Reset in the middle of a transfer
    csr_wr(2'd0, 32'd300);
    csr_wr(2'd1, 32'd8);
    start_xfer();
    repeat (3) @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("mid_rst_cs", {31'b0, bank_chipselect}, 32'd0);
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    csr_rd(2'd2, rd); check("mid_rst_status", rd, 32'd0);
    csr_rd(2'd0, rd); check("mid_rst_start", rd, 32'd0);
    csr_rd(2'd1, rd); check("mid_rst_len", rd, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    out_q.delete(); iss_q.delete(); n_iss = 0;
    repeat (10) @(posedge clk); #1;
    check("post_rst_issues", n_iss, 32'd0);
    check("post_rst_words", out_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
